// File: rtl/resize_pkg.sv
// Shared constants for the 2x downscale sequencer: state encoding, mode codes,
// per-mode block timing and the mode legality helper.
package resize_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD0  = 3'd1;
  localparam logic [2:0] ST_RD1  = 3'd2;
  localparam logic [2:0] ST_RD2  = 3'd3;
  localparam logic [2:0] ST_RD3  = 3'd4;
  localparam logic [2:0] ST_WAIT = 3'd5;
  localparam logic [2:0] ST_WR   = 3'd6;
  localparam logic [2:0] ST_DONE = 3'd7;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_AVG = 2'b00;
  localparam mode_t MODE_DEC = 2'b01;

  localparam int CYC_PER_BLK_AVG = 6;
  localparam int CYC_PER_BLK_DEC = 3;

  // Codes 1x are reserved and rejected at start.
  function automatic logic mode_legal(input mode_t m);
    return !m[1];
  endfunction

endpackage

// File: rtl/resize_addr_gen.sv
// Block counters (oy, ox) with wrap and last-block flag, plus combinational
// source/destination address generation from the counters and read phase.
module resize_addr_gen
  import resize_pkg::*;
#(
  parameter int SRC_W  = 8,
  parameter int SRC_H  = 8,
  parameter int SRC_AW = 6,
  parameter int DST_AW = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              step,
  input  logic [1:0]        phase,
  output logic              last,
  output logic [SRC_AW-1:0] src_addr,
  output logic [DST_AW-1:0] dst_addr
);

  localparam int BW = SRC_W / 2;
  localparam int BH = SRC_H / 2;

  logic [DST_AW-1:0] ox_reg, ox_next;
  logic [DST_AW-1:0] oy_reg, oy_next;
  logic              ox_last, oy_last;

  assign ox_last = (ox_reg == DST_AW'(BW - 1));
  assign oy_last = (oy_reg == DST_AW'(BH - 1));
  assign last    = ox_last && oy_last;

  always_comb begin
    ox_next = ox_reg;
    oy_next = oy_reg;
    if (clear) begin
      ox_next = '0;
      oy_next = '0;
    end else if (step) begin
      if (ox_last) begin
        ox_next = '0;
        oy_next = oy_reg + DST_AW'(1);
      end else begin
        ox_next = ox_reg + DST_AW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ox_reg <= '0;
      oy_reg <= '0;
    end else begin
      ox_reg <= ox_next;
      oy_reg <= oy_next;
    end
  end

  // phase[1] selects the lower row of the block, phase[0] the right column.
  assign src_addr = SRC_AW'((2 * int'(oy_reg) + int'(phase[1])) * SRC_W
                            + 2 * int'(ox_reg) + int'(phase[0]));
  assign dst_addr = DST_AW'(int'(oy_reg) * BW + int'(ox_reg));

endmodule

// File: rtl/resize_sequencer.sv
// 2x downscale sequencer: walks the source frame in 2x2 blocks, averages or
// decimates each block, writes one pixel per block. RESIZE_ROUND_EN rounds the average.
module resize_sequencer
  import resize_pkg::*;
#(
  parameter int SRC_W  = 8,
  parameter int SRC_H  = 8,
  parameter int PIX_W  = 8,
  parameter int SRC_AW = 6,
  parameter int DST_AW = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              abort,
  output logic              src_rd_en,
  output logic [SRC_AW-1:0] src_rd_addr,
  input  logic [PIX_W-1:0]  src_rd_data,
  output logic              dst_wr_en,
  output logic [DST_AW-1:0] dst_wr_addr,
  output logic [PIX_W-1:0]  dst_wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  logic [2:0]       state_reg, state_next;
  mode_t            mode_reg, mode_next;
  logic [PIX_W+1:0] acc_reg, acc_next;
  logic             err_reg, err_next;

  logic              accept, is_rd, is_wr, last_blk;
  logic [1:0]        phase;
  logic [SRC_AW-1:0] gen_src_addr;
  logic [DST_AW-1:0] gen_dst_addr;
  logic [PIX_W-1:0]  result;

  assign accept = (state_reg == ST_IDLE) && start && mode_legal(mode);
  assign is_rd  = (state_reg >= ST_RD0) && (state_reg <= ST_RD3);
  assign is_wr  = (state_reg == ST_WR);
  assign busy   = (state_reg != ST_IDLE) && (state_reg != ST_DONE);

  always_comb begin
    phase = 2'b00;
    case (state_reg)
      ST_RD1:  phase = 2'b01;
      ST_RD2:  phase = 2'b10;
      ST_RD3:  phase = 2'b11;
      default: phase = 2'b00;
    endcase
  end

  resize_addr_gen #(
    .SRC_W (SRC_W),
    .SRC_H (SRC_H),
    .SRC_AW(SRC_AW),
    .DST_AW(DST_AW)
  ) u_addr_gen (
    .clock   (clock),
    .reset   (reset),
    .clear   (accept),
    .step    (is_wr),
    .phase   (phase),
    .last    (last_blk),
    .src_addr(gen_src_addr),
    .dst_addr(gen_dst_addr)
  );

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    acc_next   = acc_reg;
    err_next   = (state_reg == ST_IDLE) && start && !mode_legal(mode);
    case (state_reg)
      ST_IDLE: if (accept) begin
        state_next = ST_RD0;
        mode_next  = mode;
      end
      ST_RD0: begin
        acc_next   = '0;
        state_next = (mode_reg == MODE_DEC) ? ST_WAIT : ST_RD1;
      end
      ST_RD1:  state_next = ST_RD2;
      ST_RD2:  state_next = ST_RD3;
      ST_RD3:  state_next = ST_WAIT;
      ST_WAIT: state_next = ST_WR;
      ST_WR:   state_next = last_blk ? ST_DONE : ST_RD0;
      default: state_next = ST_IDLE;
    endcase
    // Read data lands one cycle after each RDx, i.e. in RD1..RD3 and WAIT.
    if ((state_reg >= ST_RD1) && (state_reg <= ST_WAIT))
      acc_next = acc_reg + {2'b00, src_rd_data};
    if (busy && abort)
      state_next = ST_IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      mode_reg  <= MODE_AVG;
      acc_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
      acc_reg   <= acc_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
`ifdef RESIZE_ROUND_EN
    result = PIX_W'((acc_reg + (PIX_W+2)'(2)) >> 2);
`else
    result = PIX_W'(acc_reg >> 2);
`endif
    if (mode_reg == MODE_DEC)
      result = acc_reg[PIX_W-1:0];
  end

  assign src_rd_en   = is_rd;
  assign src_rd_addr = is_rd ? gen_src_addr : '0;
  assign dst_wr_en   = is_wr;
  assign dst_wr_addr = is_wr ? gen_dst_addr : '0;
  assign dst_wr_data = is_wr ? result : '0;
  assign done        = (state_reg == ST_DONE);
  assign err         = err_reg;

endmodule
